// File: rtl/square_writer.sv
// square_writer
//   Drawing front end for the framebuffer memory. Accepts "fill rectangle" and
//   "clear" commands over a valid/ready handshake. Each rectangle becomes one
//   memory write per cycle. The block drives the memory write port directly.
//   The grid is row-major, so a cell address is {y, x}.
//
// Ports
//   clock        single clock; all state changes on its rising edge
//   reset        asynchronous, active-low
//   cmd_valid    a command is present on the cmd_* inputs
//   cmd_ready    a command is accepted on this edge if cmd_valid is high
//   cmd_clear    1 = clear the whole frame; the geometry and colour inputs are ignored
//   cmd_x/cmd_y  top-left cell of the rectangle
//   cmd_w/cmd_h  rectangle size in cells; may be zero or the full grid extent
//   cmd_color    fill colour
//   mem_address  memory address_in (registered)
//   mem_data     memory data_in (registered)
//   mem_wren     memory write enable (registered)
//   mem_reset    memory clear strobe, active-high (registered)
//   done         one-cycle pulse when a command completes (registered)
module square_writer #(
  parameter int A      = 9,
  parameter int S      = 24,
  parameter int X_BITS = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [X_BITS-1:0] cmd_x,
  input  logic [A-X_BITS-1:0] cmd_y,
  input  logic [X_BITS:0]   cmd_w,
  input  logic [A-X_BITS:0] cmd_h,
  input  logic [S-1:0]      cmd_color,
  output logic [A-1:0]      mem_address,
  output logic [S-1:0]      mem_data,
  output logic              mem_wren,
  output logic              mem_reset,
  output logic              done
);

  localparam int YB = A - X_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRAW   = 2'd1;
  localparam logic [1:0] CLEAR  = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  localparam logic [X_BITS:0] GRID_W = {1'b1, {X_BITS{1'b0}}};
  localparam logic [YB:0]     GRID_H = {1'b1, {YB{1'b0}}};
  localparam logic [X_BITS:0] X_ONE  = {{X_BITS{1'b0}}, 1'b1};
  localparam logic [YB:0]     Y_ONE  = {{YB{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [X_BITS-1:0] x0_q, x0_d;
  logic [YB-1:0]     y0_q, y0_d;
  logic [X_BITS:0]   wEff_q, wEff_d;
  logic [YB:0]       hEff_q, hEff_d;
  logic [X_BITS:0]   xCnt_q, xCnt_d;
  logic [YB:0]       yCnt_q, yCnt_d;
  logic [A-1:0]      addr_q, addr_d;
  logic [S-1:0]      data_q, data_d;
  logic              wren_q, wren_d;
  logic              memReset_q, memReset_d;
  logic              done_q, done_d;

  logic [X_BITS:0]   remX, wClip;
  logic [YB:0]       remY, hClip;
  logic              accept;
  logic              xLast, yLast;

  // The done cycle (FINISH) also accepts a command. This lets a new command
  // be taken on the edge that ends the done pulse, with no idle cycle between.
  assign cmd_ready = (state_q == IDLE) || (state_q == FINISH);
  assign accept    = cmd_valid && cmd_ready;

  // Clip the rectangle against the right and bottom edges at accept time.
  // The widened arithmetic keeps a full-width request from overflowing,
  // and the clip guarantees that no address ever wraps.
  assign remX  = GRID_W - {1'b0, cmd_x};
  assign remY  = GRID_H - {1'b0, cmd_y};
  assign wClip = (cmd_w > remX) ? remX : cmd_w;
  assign hClip = (cmd_h > remY) ? remY : cmd_h;

  assign xLast = (xCnt_q == wEff_q - X_ONE);
  assign yLast = (yCnt_q == hEff_q - Y_ONE);

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    wEff_d     = wEff_q;
    hEff_d     = hEff_q;
    xCnt_d     = xCnt_q;
    yCnt_d     = yCnt_q;
    addr_d     = addr_q;
    data_d     = data_q;
    wren_d     = 1'b0;
    memReset_d = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (accept) begin
          x0_d   = cmd_x;
          y0_d   = cmd_y;
          wEff_d = wClip;
          hEff_d = hClip;
          xCnt_d = '0;
          yCnt_d = '0;
          if (cmd_clear) begin
            state_d    = CLEAR;
            memReset_d = 1'b1;
          end else if (wClip == '0 || hClip == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            // The first write is presented in the cycle right after accept.
            state_d = DRAW;
            wren_d  = 1'b1;
            addr_d  = {cmd_y, cmd_x};
            data_d  = cmd_color;
          end
        end
      end

      CLEAR: begin
        state_d = FINISH;
        done_d  = 1'b1;
      end

      DRAW: begin
        if (xLast && yLast) begin
          state_d = FINISH;
          done_d  = 1'b1;
        end else begin
          // x steps fastest; at the end of a row it returns to the left edge.
          if (xLast) begin
            xCnt_d = '0;
            yCnt_d = yCnt_q + Y_ONE;
          end else begin
            xCnt_d = xCnt_q + X_ONE;
          end
          wren_d = 1'b1;
          addr_d = {y0_q + yCnt_d[YB-1:0], x0_q + xCnt_d[X_BITS-1:0]};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      wEff_q     <= '0;
      hEff_q     <= '0;
      xCnt_q     <= '0;
      yCnt_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      wren_q     <= 1'b0;
      memReset_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      wEff_q     <= wEff_d;
      hEff_q     <= hEff_d;
      xCnt_q     <= xCnt_d;
      yCnt_q     <= yCnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      wren_q     <= wren_d;
      memReset_q <= memReset_d;
      done_q     <= done_d;
    end
  end

  assign mem_address = addr_q;
  assign mem_data    = data_q;
  assign mem_wren    = wren_q;
  assign mem_reset   = memReset_q;
  assign done        = done_q;

endmodule

// File: tb/tb_square_writer.sv
// Directed testbench for square_writer: each scenario drives commands and
// checks the memory-side outputs against hand-computed values cycle by cycle.
module tb_square_writer;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_clear;
  logic [4:0]  cmd_x;
  logic [3:0]  cmd_y;
  logic [5:0]  cmd_w;
  logic [4:0]  cmd_h;
  logic [23:0] cmd_color;
  logic [8:0]  mem_address;
  logic [23:0] mem_data;
  logic        mem_wren;
  logic        mem_reset;
  logic        done;

  int assertCount = 0;
  int failCount   = 0;

  square_writer #(.A(9), .S(24), .X_BITS(5)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_clear  (cmd_clear),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .mem_address(mem_address),
    .mem_data   (mem_data),
    .mem_wren   (mem_wren),
    .mem_reset  (mem_reset),
    .done       (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drives a command, waits for the accepting edge, then withdraws it.
  task automatic sendCmd(input logic clr, input logic [4:0] x, input logic [3:0] y,
                         input logic [5:0] w, input logic [4:0] h, input logic [23:0] col);
    cmd_valid = 1'b1;
    cmd_clear = clr;
    cmd_x     = x;
    cmd_y     = y;
    cmd_w     = w;
    cmd_h     = h;
    cmd_color = col;
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    cmd_valid = 1'b0;
    cmd_clear = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    #12;
    assertCount++;
    if ({mem_wren, mem_reset, done} !== 3'b000) begin
      failCount++;
      $display("[TB] FAIL reset_ctrl: got %b, expected 000", {mem_wren, mem_reset, done});
    end
    assertCount++;
    if (mem_address !== 9'h000 || mem_data !== 24'h0) begin
      failCount++;
      $display("[TB] FAIL reset_addr_data: got %h/%h, expected 000/000000", mem_address, mem_data);
    end
    assertCount++;
    if (cmd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL reset_ready: got %b, expected 1", cmd_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_basic_fill();
    logic [8:0] expAddr [4];
    expAddr[0] = 9'h062; expAddr[1] = 9'h063; expAddr[2] = 9'h082; expAddr[3] = 9'h083;
    sendCmd(1'b0, 5'd2, 4'd3, 6'd2, 5'd2, 24'hFF0000);
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      assertCount++;
      if (mem_wren !== 1'b1 || mem_address !== expAddr[k] || mem_data !== 24'hFF0000) begin
        failCount++;
        $display("[TB] FAIL fill_write%0d: got wren=%b addr=%h data=%h, expected 1 %h FF0000",
                 k, mem_wren, mem_address, mem_data, expAddr[k]);
      end
      assertCount++;
      if (cmd_ready !== 1'b0 || done !== 1'b0) begin
        failCount++;
        $display("[TB] FAIL fill_busy%0d: got ready=%b done=%b, expected 0 0", k, cmd_ready, done);
      end
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL fill_done: got done=%b wren=%b, expected 1 0", done, mem_wren);
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b0 || cmd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL fill_idle: got done=%b ready=%b, expected 0 1", done, cmd_ready);
    end
  endtask

  task automatic test_clip();
    logic [8:0] expAddr [2];
    expAddr[0] = 9'h1FE; expAddr[1] = 9'h1FF;
    sendCmd(1'b0, 5'd30, 4'd15, 6'd5, 5'd3, 24'h123456);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      assertCount++;
      if (mem_wren !== 1'b1 || mem_address !== expAddr[k] || mem_data !== 24'h123456) begin
        failCount++;
        $display("[TB] FAIL clip_write%0d: got wren=%b addr=%h data=%h, expected 1 %h 123456",
                 k, mem_wren, mem_address, mem_data, expAddr[k]);
      end
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL clip_done: got done=%b wren=%b, expected 1 0", done, mem_wren);
    end
    @(negedge clock);
  endtask

  task automatic test_empty();
    sendCmd(1'b0, 5'd4, 4'd1, 6'd0, 5'd7, 24'hABCDEF);
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL empty_done: got done=%b wren=%b, expected 1 0", done, mem_wren);
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b0 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL empty_after: got done=%b wren=%b, expected 0 0", done, mem_wren);
    end
  endtask

  task automatic test_full_frame();
    int badWrites = 0;
    logic [8:0] expAddr;
    sendCmd(1'b0, 5'd0, 4'd0, 6'd32, 5'd16, 24'h00AA55);
    for (int k = 0; k < 512; k++) begin
      @(negedge clock);
      expAddr = 9'(k);
      assertCount++;
      if (mem_wren !== 1'b1 || mem_address !== expAddr || done !== 1'b0) begin
        failCount++;
        badWrites++;
        if (badWrites < 4)
          $display("[TB] FAIL full_write%0d: got wren=%b addr=%h done=%b, expected 1 %h 0",
                   k, mem_wren, mem_address, done, expAddr);
      end
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL full_done: got done=%b wren=%b, expected 1 0", done, mem_wren);
    end
    @(negedge clock);
  endtask

  task automatic test_clear();
    sendCmd(1'b1, 5'd7, 4'd7, 6'd3, 5'd3, 24'hFFFFFF);
    @(negedge clock);
    assertCount++;
    if (mem_reset !== 1'b1 || mem_wren !== 1'b0 || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL clear_pulse: got rst=%b wren=%b done=%b, expected 1 0 0",
               mem_reset, mem_wren, done);
    end
    @(negedge clock);
    assertCount++;
    if (mem_reset !== 1'b0 || mem_wren !== 1'b0 || done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL clear_done: got rst=%b wren=%b done=%b, expected 0 0 1",
               mem_reset, mem_wren, done);
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid_draw();
    int doneSeen = 0;
    sendCmd(1'b0, 5'd0, 4'd0, 6'd4, 5'd4, 24'h0F0F0F);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock);
    assertCount++;
    if (mem_wren !== 1'b1 || mem_address !== 9'h002) begin
      failCount++;
      $display("[TB] FAIL abort_third: got wren=%b addr=%h, expected 1 002", mem_wren, mem_address);
    end
    reset = 1'b0;
    #1;
    assertCount++;
    if (mem_wren !== 1'b0 || done !== 1'b0 || mem_address !== 9'h000 || mem_data !== 24'h0) begin
      failCount++;
      $display("[TB] FAIL abort_async: got wren=%b done=%b addr=%h data=%h, expected 0 0 000 000000",
               mem_wren, done, mem_address, mem_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (done === 1'b1) doneSeen++;
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      if (done === 1'b1 || mem_wren === 1'b1) doneSeen++;
    end
    assertCount++;
    if (doneSeen != 0) begin
      failCount++;
      $display("[TB] FAIL abort_no_done: got %0d done/wren cycles, expected 0", doneSeen);
    end
    assertCount++;
    if (cmd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL abort_ready: got %b, expected 1", cmd_ready);
    end
    sendCmd(1'b0, 5'd0, 4'd0, 6'd1, 5'd1, 24'h00FF00);
    @(negedge clock);
    assertCount++;
    if (mem_wren !== 1'b1 || mem_address !== 9'h000 || mem_data !== 24'h00FF00) begin
      failCount++;
      $display("[TB] FAIL abort_next_write: got wren=%b addr=%h data=%h, expected 1 000 00FF00",
               mem_wren, mem_address, mem_data);
    end
    @(negedge clock);
    assertCount++;
    if (mem_wren !== 1'b0 || done !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL abort_next_done: got wren=%b done=%b, expected 0 1", mem_wren, done);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    // Command A: 2x1 at (4,1) -> 024,025. Command B: 1x2 at (10,2) -> 04A,06A.
    sendCmd(1'b0, 5'd4, 4'd1, 6'd2, 5'd1, 24'h00FF00);
    cmd_valid = 1'b1;
    cmd_x = 5'd10; cmd_y = 4'd2; cmd_w = 6'd1; cmd_h = 5'd2; cmd_color = 24'h0000FF;
    @(negedge clock);
    assertCount++;
    if (mem_address !== 9'h024 || mem_wren !== 1'b1 || cmd_ready !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_a1: got addr=%h wren=%b ready=%b, expected 024 1 0",
               mem_address, mem_wren, cmd_ready);
    end
    @(negedge clock);
    assertCount++;
    if (mem_address !== 9'h025 || mem_wren !== 1'b1 || mem_data !== 24'h00FF00) begin
      failCount++;
      $display("[TB] FAIL b2b_a2: got addr=%h wren=%b data=%h, expected 025 1 00FF00",
               mem_address, mem_wren, mem_data);
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_a_done: got done=%b ready=%b wren=%b, expected 1 1 0",
               done, cmd_ready, mem_wren);
    end
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    @(negedge clock);
    assertCount++;
    if (mem_address !== 9'h04A || mem_wren !== 1'b1 || mem_data !== 24'h0000FF || done !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_b1: got addr=%h wren=%b data=%h done=%b, expected 04A 1 0000FF 0",
               mem_address, mem_wren, mem_data, done);
    end
    @(negedge clock);
    assertCount++;
    if (mem_address !== 9'h06A || mem_wren !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_b2: got addr=%h wren=%b, expected 06A 1", mem_address, mem_wren);
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b1 || mem_wren !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL b2b_b_done: got done=%b wren=%b, expected 1 0", done, mem_wren);
    end
    @(negedge clock);
    assertCount++;
    if (done !== 1'b0 || mem_wren !== 1'b0 || cmd_ready !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL b2b_idle: got done=%b wren=%b ready=%b, expected 0 0 1",
               done, mem_wren, cmd_ready);
    end
  endtask

  initial begin
    $display("[TB] square_writer directed test start");
    test_reset();
    test_basic_fill();
    test_clip();
    test_empty();
    test_full_frame();
    test_clear();
    test_reset_mid_draw();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
